// File: rtl/baccarat_pkg.sv
// Shared types, thresholds and the card-rank helper for the baccarat controller.
// Optional debug build: define BACC_STATE_DBG_EN to expose the state register.
package baccarat_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned RANK_W  = 4;
    localparam int unsigned STATE_W = 4;

    localparam logic [SCORE_W-1:0] NAT_MIN_C   = 4'd8;
    localparam logic [SCORE_W-1:0] STAND_MIN_C = 4'd6;

    typedef enum logic [STATE_W-1:0] {
        DEAL_P1  = 4'd0,
        DEAL_D1  = 4'd1,
        DEAL_P2  = 4'd2,
        DEAL_D2  = 4'd3,
        EVAL     = 4'd4,
        DEAL_P3  = 4'd5,
        BANK_DEC = 4'd6,
        DEAL_D3  = 4'd7,
        DONE     = 4'd8
    } state_t;

    typedef struct packed {
        logic pcard1;
        logic pcard2;
        logic pcard3;
        logic dcard1;
        logic dcard2;
        logic dcard3;
    } load_t;

    // Tens and face cards count as zero.
    function automatic logic [SCORE_W-1:0] card_value(input logic [RANK_W-1:0] rank);
        return (rank >= 4'd10) ? 4'd0 : SCORE_W'(rank);
    endfunction

endpackage

// File: rtl/baccarat_banker_rule.sv
// Banker third-card drawing table: banker two-card score and player third-card value -> draw.
module baccarat_banker_rule
    import baccarat_pkg::*;
(
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] third_value,
    output logic               draw_c
);

    always_comb begin
        draw_c = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw_c = 1'b1;
            4'd3:             draw_c = (third_value != 4'd8);
            4'd4:             draw_c = (third_value >= 4'd2) && (third_value <= 4'd7);
            4'd5:             draw_c = (third_value >= 4'd4) && (third_value <= 4'd7);
            4'd6:             draw_c = (third_value >= 4'd6) && (third_value <= 4'd7);
            default:          draw_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_ctrl.sv
// Deal-sequencing FSM for the baccarat datapath: card load enables, third-card rules, winner flags.
// Define BACC_STATE_DBG_EN to add the state_dbg port and the one-hot load check.
module baccarat_ctrl
    import baccarat_pkg::*;
(
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic [RANK_W-1:0]  pcard3_in,
    input  logic [SCORE_W-1:0] pscore,
    input  logic [SCORE_W-1:0] dscore,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win,
    output logic               dealer_win
`ifdef BACC_STATE_DBG_EN
    ,
    output logic [STATE_W-1:0] state_dbg
`endif
);

    state_t state;
    state_t state_nxt;
    load_t  load_c;
    logic   bank_draw_c;

    baccarat_banker_rule u_banker_rule (
        .dscore      (dscore),
        .third_value (card_value(pcard3_in)),
        .draw_c      (bank_draw_c)
    );

    // State register; reset restarts the deal from the first player card.
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            state <= DEAL_P1;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore loads; everything is held low while reset is asserted.
    always_comb begin
        state_nxt  = state;
        load_c     = '0;
        player_win = 1'b0;
        dealer_win = 1'b0;
        case (state)
            DEAL_P1: begin
                load_c.pcard1 = 1'b1;
                state_nxt     = DEAL_D1;
            end
            DEAL_D1: begin
                load_c.dcard1 = 1'b1;
                state_nxt     = DEAL_P2;
            end
            DEAL_P2: begin
                load_c.pcard2 = 1'b1;
                state_nxt     = DEAL_D2;
            end
            DEAL_D2: begin
                load_c.dcard2 = 1'b1;
                state_nxt     = EVAL;
            end
            EVAL: begin
                if ((pscore >= NAT_MIN_C) || (dscore >= NAT_MIN_C)) begin
                    state_nxt = DONE;
                end else if (pscore < STAND_MIN_C) begin
                    state_nxt = DEAL_P3;
                end else if (dscore < STAND_MIN_C) begin
                    state_nxt = DEAL_D3;
                end else begin
                    state_nxt = DONE;
                end
            end
            DEAL_P3: begin
                load_c.pcard3 = 1'b1;
                state_nxt     = BANK_DEC;
            end
            BANK_DEC: begin
                state_nxt = bank_draw_c ? DEAL_D3 : DONE;
            end
            DEAL_D3: begin
                load_c.dcard3 = 1'b1;
                state_nxt     = DONE;
            end
            DONE: begin
                player_win = (pscore >= dscore);
                dealer_win = (dscore >= pscore);
            end
            default: begin
                state_nxt = DEAL_P1;
            end
        endcase
        if (resetb) begin
            load_c     = '0;
            player_win = 1'b0;
            dealer_win = 1'b0;
        end
    end

    assign load_pcard1 = load_c.pcard1;
    assign load_pcard2 = load_c.pcard2;
    assign load_pcard3 = load_c.pcard3;
    assign load_dcard1 = load_c.dcard1;
    assign load_dcard2 = load_c.dcard2;
    assign load_dcard3 = load_c.dcard3;

`ifdef BACC_STATE_DBG_EN
    assign state_dbg = STATE_W'(state);

    a_one_load: assert property (@(posedge slow_clock) $onehot0(load_c));
`endif

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Bench for baccarat_ctrl: card-register datapath stand-in, per-hand game model, banker table sweep.
module tb_baccarat_ctrl;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b1;
    logic [3:0] pcard3_in;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win, dealer_win;

    int errors = 0;
    int checks = 0;

    always #5 slow_clock = ~slow_clock;

    baccarat_ctrl dut (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .pcard3_in   (pcard3_in),
        .pscore      (pscore),
        .dscore      (dscore),
        .load_pcard1 (load_pcard1),
        .load_pcard2 (load_pcard2),
        .load_pcard3 (load_pcard3),
        .load_dcard1 (load_dcard1),
        .load_dcard2 (load_dcard2),
        .load_dcard3 (load_dcard3),
        .player_win  (player_win),
        .dealer_win  (dealer_win)
    );

    logic [3:0] rule_d;
    logic [3:0] rule_v;
    logic       rule_draw;

    baccarat_banker_rule u_rule (
        .dscore      (rule_d),
        .third_value (rule_v),
        .draw_c      (rule_draw)
    );

    // Deck slots in deal order: P1, D1, P2, D2, P3, D3.
    logic [3:0] deck [6];
    logic [3:0] creg [6];

    function automatic int cv(input int r);
        return (r >= 10) ? 0 : r;
    endfunction

    always @(posedge slow_clock) begin
        if (resetb) begin
            for (int i = 0; i < 6; i++) creg[i] <= 4'd0;
        end else begin
            if (load_pcard1) creg[0] <= deck[0];
            if (load_dcard1) creg[1] <= deck[1];
            if (load_pcard2) creg[2] <= deck[2];
            if (load_dcard2) creg[3] <= deck[3];
            if (load_pcard3) creg[4] <= deck[4];
            if (load_dcard3) creg[5] <= deck[5];
        end
    end

    assign pscore    = 4'((cv(int'(creg[0])) + cv(int'(creg[2])) + cv(int'(creg[4]))) % 10);
    assign dscore    = 4'((cv(int'(creg[1])) + cv(int'(creg[3])) + cv(int'(creg[5]))) % 10);
    assign pcard3_in = creg[4];

    // Observation vector {pwin, dwin, D3, D2, D1, P3, P2, P1}.
    localparam logic [7:0] L_P1 = 8'h01, L_P2 = 8'h02, L_P3 = 8'h04;
    localparam logic [7:0] L_D1 = 8'h08, L_D2 = 8'h10, L_D3 = 8'h20;

    wire [7:0] obs = {player_win, dealer_win, load_dcard3, load_dcard2,
                      load_dcard1, load_pcard3, load_pcard2, load_pcard1};

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    // Punto banco rules straight from the table of when the banker draws.
    function automatic bit model_bank_draws(input int d, input int v);
        if (d <= 2) return 1'b1;
        if (d == 3) return v != 8;
        if (d == 4) return v >= 2 && v <= 7;
        if (d == 5) return v >= 4 && v <= 7;
        if (d == 6) return v >= 6 && v <= 7;
        return 1'b0;
    endfunction

    // Model builds the per-cycle load trace of the hand, then checks it and the DONE flags.
    task automatic run_hand(input string tag, input int c[6], input logic [1:0] lit_flags, input int lit_len);
        logic [7:0] q[$];
        logic [7:0] hist[$];
        int p, d;
        q = {};
        hist = {};
        p = (cv(c[0]) + cv(c[2])) % 10;
        d = (cv(c[1]) + cv(c[3])) % 10;
        q.push_back(L_P1); q.push_back(L_D1); q.push_back(L_P2); q.push_back(L_D2);
        q.push_back(8'h00);
        if (p >= 8 || d >= 8) begin
        end else if (p < 6) begin
            q.push_back(L_P3);
            q.push_back(8'h00);
            if (model_bank_draws(d, cv(c[4]))) begin
                q.push_back(L_D3);
                d = (d + cv(c[5])) % 10;
            end
            p = (p + cv(c[4])) % 10;
        end else if (d < 6) begin
            q.push_back(L_D3);
            d = (d + cv(c[5])) % 10;
        end
        for (int i = 0; i < 6; i++) deck[i] = 4'(c[i]);

        @(posedge slow_clock); #1 resetb = 1'b1;
        @(negedge slow_clock);
        check8($sformatf("%s reset", tag), obs, 8'h00);
        @(posedge slow_clock); #1 resetb = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge slow_clock);
            hist.push_back(obs);
            check8($sformatf("%s cyc%0d", tag, i), obs, q[i]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge slow_clock);
            hist.push_back(obs);
            check8($sformatf("%s done%0d", tag, k), obs,
                   {(p >= d) ? 1'b1 : 1'b0, (d >= p) ? 1'b1 : 1'b0, 6'b0});
        end
        if (lit_len < hist.size()) begin
            check8($sformatf("%s literal", tag), hist[lit_len], {lit_flags, 6'b0});
        end else begin
            checks++;
            errors++;
            $display("FAIL %s literal out_of_range got_len=%0d required_idx=%0d", tag, hist.size(), lit_len);
        end
    endtask

    function automatic bit table_draw(input int d, input int r);
        logic [13:0] m;
        case (d)
            0, 1, 2: m = 14'h3FFE;
            3:       m = 14'h3EFE;
            4:       m = 14'h00FC;
            5:       m = 14'h00F0;
            6:       m = 14'h00C0;
            default: m = 14'h0000;
        endcase
        return m[r];
    endfunction

    initial begin
        bit found;
        for (int i = 0; i < 6; i++) deck[i] = 4'd0;
        rule_d = 4'd0;
        rule_v = 4'd0;

        // Natural tie 9/9.
        run_hand("nat_tie",   '{3, 4, 6, 5, 1, 1},   2'b11, 5);
        // p=4, d=7: player draws 8, banker on 7 never draws.
        run_hand("d7_stand",  '{2, 13, 2, 7, 8, 9},  2'b01, 7);
        // p=5, d=3: third card 8 stops the banker, 7 makes it draw.
        run_hand("d3_v8",     '{2, 1, 3, 2, 8, 9},   2'b11, 7);
        run_hand("d3_v7",     '{2, 1, 3, 2, 7, 4},   2'b01, 8);
        // p=7, d=4: player stands, banker draws.
        run_hand("pstand",    '{3, 2, 4, 2, 9, 5},   2'b01, 6);
        // Face-card third card counts as zero.
        run_hand("d3_queen",  '{2, 1, 3, 2, 12, 13}, 2'b10, 8);
        run_hand("d4_ten",    '{1, 2, 1, 2, 10, 3},  2'b01, 7);
        // Both stand on 7 vs 6.
        run_hand("both_stand", '{6, 3, 1, 3, 2, 2},  2'b10, 5);

        // Reset while DEAL_P3 is active aborts and restarts the deal.
        for (int i = 0; i < 6; i++) deck[i] = 4'(i == 1 ? 13 : (i == 0 || i == 2) ? 2 : (i == 3 ? 7 : 8));
        @(posedge slow_clock); #1 resetb = 1'b1;
        @(posedge slow_clock); #1 resetb = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge slow_clock);
            if (load_pcard3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset wait_p3 got=timeout expected=load_pcard3");
        end
        resetb = 1'b1;
        #1 check8("mid_reset gate", obs, 8'h00);
        @(negedge slow_clock);
        check8("mid_reset next", obs, 8'h00);
        @(posedge slow_clock); #1 resetb = 1'b0;
        @(negedge slow_clock);
        check8("mid_reset restart_p1", obs, L_P1);
        @(negedge slow_clock);
        check8("mid_reset restart_d1", obs, L_D1);

        // Exhaustive banker table over dscore 0..7 and rank 1..13.
        for (int d = 0; d < 8; d++) begin
            for (int r = 1; r < 14; r++) begin
                rule_d = 4'(d);
                rule_v = 4'(cv(r));
                #1;
                checks++;
                if (rule_draw !== table_draw(d, r)) begin
                    errors++;
                    $display("FAIL banker_rule d=%0d rank=%0d got=%b expected=%b", d, r, rule_draw, table_draw(d, r));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
